// File: rtl/branch_redirect.sv
// branch_redirect: Execute-stage control-flow resolution.
// Decides taken branches/jumps, computes the target, holds a valid/ready redirect
// request to Fetch, then flushes wrong-path instructions for FLUSH_DEPTH cycles.
// Optional feature macro: MISALIGN_EXC_EN (targets with bit 1 set raise a one-cycle
// misalign_exc pulse instead of redirecting). Undefined by default.
module branch_redirect #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned OPLEN       = 10,
    parameter int unsigned FLUSH_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_de,
    input  logic [OPLEN-1:0] decoded_op_de,
    input  logic             comp_out,
    input  logic [XLEN-1:0]  pc_de,
    input  logic [XLEN-1:0]  imm_de,
    input  logic [XLEN-1:0]  rs1data_de,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    input  logic             redirect_ready,
    output logic             flush_de,
    output logic             stall_de,
    output logic             misalign_exc
);

    typedef enum logic [1:0] {StIdle, StReq, StFlush} state_e;

    state_e          state_q;
    logic [3:0]      cnt_q;
    logic            misalign_q;
    logic            busy;
    logic            take;
    logic            misalign_hit;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] target;

    // funct3 and the remaining op bits are decoded upstream into comp_out
    logic unused_op;
    assign unused_op = ^{decoded_op_de[7:4], decoded_op_de[2:0]};

    assign busy = (state_q != StIdle);
    assign take = valid_de & ~busy & (decoded_op_de[8] | (decoded_op_de[9] & comp_out));

    // Target: JALR uses rs1 as base and clears bit 0, everything else is PC-relative
    always_comb begin
        base   = decoded_op_de[3] ? rs1data_de : pc_de;
        target = base + imm_de;
        if (decoded_op_de[3]) begin
            target[0] = 1'b0;
        end
    end

`ifdef MISALIGN_EXC_EN
    assign misalign_hit = target[1];
`else
    assign misalign_hit = 1'b0;
`endif

    assign misalign_exc = misalign_q;

    // Redirect FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= 4'd0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush_de       <= 1'b0;
            stall_de       <= 1'b0;
            misalign_q     <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    redirect_valid <= 1'b0;
                    flush_de       <= 1'b0;
                    stall_de       <= 1'b0;
                    if (take) begin
                        if (misalign_hit) begin
                            // Stay idle; kill the faulting path for one cycle only
                            misalign_q <= 1'b1;
                            flush_de   <= 1'b1;
                        end else begin
                            redirect_pc    <= target;
                            redirect_valid <= 1'b1;
                            flush_de       <= 1'b1;
                            stall_de       <= 1'b1;
                            state_q        <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (redirect_ready) begin
                        redirect_valid <= 1'b0;
                        if (FLUSH_DEPTH != 0) begin
                            cnt_q   <= 4'(FLUSH_DEPTH - 1);
                            state_q <= StFlush;
                        end else begin
                            flush_de <= 1'b0;
                            stall_de <= 1'b0;
                            state_q  <= StIdle;
                        end
                    end
                end
                StFlush: begin
                    if (cnt_q == 4'd0) begin
                        flush_de <= 1'b0;
                        stall_de <= 1'b0;
                        state_q  <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    redirect_valid <= 1'b0;
                    flush_de       <= 1'b0;
                    stall_de       <= 1'b0;
                    state_q        <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_redirect.sv
// Self-checking bench for branch_redirect (FLUSH_DEPTH=2).
// Inputs are driven and outputs sampled on the falling edge.
module tb_branch_redirect;

    logic        clk;
    logic        rst_n;
    logic        valid_de;
    logic [9:0]  decoded_op_de;
    logic        comp_out;
    logic [31:0] pc_de;
    logic [31:0] imm_de;
    logic [31:0] rs1data_de;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        flush_de;
    logic        stall_de;
    logic        misalign_exc;

    int checks   = 0;
    int failures = 0;

    localparam logic [9:0] OpAdd  = 10'h000;
    localparam logic [9:0] OpBeq  = 10'h200;
    localparam logic [9:0] OpBne  = 10'h210;
    localparam logic [9:0] OpJal  = 10'h100;
    localparam logic [9:0] OpJalr = 10'h108;

    branch_redirect #(
        .XLEN        (32),
        .OPLEN       (10),
        .FLUSH_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_de       (valid_de),
        .decoded_op_de  (decoded_op_de),
        .comp_out       (comp_out),
        .pc_de          (pc_de),
        .imm_de         (imm_de),
        .rs1data_de     (rs1data_de),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .flush_de       (flush_de),
        .stall_de       (stall_de),
        .misalign_exc   (misalign_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [9:0]  op;
        logic        comp;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic        ready;
        logic        exp_rv;
        logic [31:0] exp_pc;
        logic        exp_flush;
        logic        exp_stall;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(logic v, logic [9:0] op, logic c, logic [31:0] pc,
                                logic [31:0] imm, logic [31:0] rs1, logic rdy,
                                logic erv, logic [31:0] epc, logic efl, logic est);
        vec_t r;
        r.valid = v; r.op = op; r.comp = c; r.pc = pc; r.imm = imm; r.rs1 = rs1;
        r.ready = rdy; r.exp_rv = erv; r.exp_pc = epc; r.exp_flush = efl;
        r.exp_stall = est;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic rv, input logic [31:0] pc,
                             input logic fl, input logic st, input logic mx);
        check({tag, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, rv});
        check({tag, ".redirect_pc"}, redirect_pc, pc);
        check({tag, ".flush_de"}, {31'd0, flush_de}, {31'd0, fl});
        check({tag, ".stall_de"}, {31'd0, stall_de}, {31'd0, st});
        check({tag, ".misalign_exc"}, {31'd0, misalign_exc}, {31'd0, mx});
    endtask

    task automatic drive(input logic v, input logic [9:0] op, input logic c,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic rdy);
        valid_de = v; decoded_op_de = op; comp_out = c; pc_de = pc; imm_de = imm;
        rs1data_de = rs1; redirect_ready = rdy;
    endtask

    task automatic idle_inputs();
        drive(1'b0, OpAdd, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        // idle, not-taken, then a BEQ with 2 cycles of back-pressure, then JALR
        vecs[0]  = mk(1, OpAdd,  0, 32'h100, 32'h40, 32'h0,    0, 0, 32'h0,    0, 0);
        vecs[1]  = mk(1, OpBne,  0, 32'h100, 32'h40, 32'h0,    1, 0, 32'h0,    0, 0);
        vecs[2]  = mk(1, OpBeq,  0, 32'h100, 32'h20, 32'h0,    0, 0, 32'h0,    0, 0);
        vecs[3]  = mk(1, OpBeq,  1, 32'h100, 32'h20, 32'h0,    0, 1, 32'h120,  1, 1);
        vecs[4]  = mk(0, OpAdd,  0, 32'h0,   32'h0,  32'h0,    0, 1, 32'h120,  1, 1);
        vecs[5]  = mk(0, OpAdd,  0, 32'h0,   32'h0,  32'h0,    1, 0, 32'h120,  1, 1);
        vecs[6]  = mk(1, OpJal,  0, 32'h40,  32'h8,  32'h0,    1, 0, 32'h120,  1, 1);
        vecs[7]  = mk(0, OpAdd,  0, 32'h0,   32'h0,  32'h0,    1, 0, 32'h120,  0, 0);
        vecs[8]  = mk(1, OpJalr, 0, 32'h700, 32'h4,  32'h1003, 1, 1, 32'h1006, 1, 1);
        vecs[9]  = mk(0, OpAdd,  0, 32'h0,   32'h0,  32'h0,    1, 0, 32'h1006, 1, 1);
        vecs[10] = mk(0, OpAdd,  0, 32'h0,   32'h0,  32'h0,    0, 0, 32'h1006, 1, 1);
        vecs[11] = mk(0, OpAdd,  0, 32'h0,   32'h0,  32'h0,    0, 0, 32'h1006, 0, 0);
        vecs[12] = mk(1, OpJal,  0, 32'h300, 32'h10, 32'h0,    0, 1, 32'h310,  1, 1);

        repeat (2) @(negedge clk);
        check_all("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].valid, vecs[i].op, vecs[i].comp, vecs[i].pc, vecs[i].imm,
                  vecs[i].rs1, vecs[i].ready);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), vecs[i].exp_rv, vecs[i].exp_pc,
                      vecs[i].exp_flush, vecs[i].exp_stall, 1'b0);
        end

        // Back-pressure: request from vec12 held 5 cycles; a second take is ignored
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, OpBeq, 1'b1, 32'h500, 32'h8, 32'h0, 1'b0);
            @(negedge clk);
            check_all($sformatf("bp%0d", i), 1'b1, 32'h310, 1'b1, 1'b1, 1'b0);
        end
        drive(1'b1, OpBeq, 1'b1, 32'h500, 32'h8, 32'h0, 1'b1);
        @(negedge clk);
        check_all("bp_hs", 1'b0, 32'h310, 1'b1, 1'b1, 1'b0);
        drive(1'b1, OpBeq, 1'b1, 32'h500, 32'h8, 32'h0, 1'b0);
        @(negedge clk);
        check_all("bp_fl", 1'b0, 32'h310, 1'b1, 1'b1, 1'b0);
        idle_inputs();
        @(negedge clk);
        check_all("bp_idle", 1'b0, 32'h310, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a request drops it asynchronously
        drive(1'b1, OpBeq, 1'b1, 32'h800, 32'h40, 32'h0, 1'b0);
        @(negedge clk);
        check_all("pre_rst", 1'b1, 32'h840, 1'b1, 1'b1, 1'b0);
        idle_inputs();
        #2 rst_n = 1'b0;
        #1 check_all("async_rst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("post_rst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // JAL to a target with bit 1 set
        drive(1'b1, OpJal, 1'b0, 32'h200, 32'h2, 32'h0, 1'b0);
        @(negedge clk);
`ifdef MISALIGN_EXC_EN
        check_all("mis", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        idle_inputs();
        @(negedge clk);
        check_all("mis_end", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
`else
        check_all("mis", 1'b1, 32'h202, 1'b1, 1'b1, 1'b0);
        drive(1'b0, OpAdd, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        check_all("mis_hs", 1'b0, 32'h202, 1'b1, 1'b1, 1'b0);
        idle_inputs();
        repeat (2) @(negedge clk);
        check_all("mis_end", 1'b0, 32'h202, 1'b0, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_redirect.md
# branch_redirect

Resolves control-flow in the Execute stage. Each valid instruction's decoded op and the `comp` result (`comp_out`) decide whether the PC changes. On a taken branch or jump the block computes the target and holds a valid/ready redirect request to Fetch until Fetch accepts it. It then flushes the wrong-path instructions for a fixed number of cycles and drives a stall to Decode while busy.

## Interface
- XLEN, 32, data/address width
- OPLEN, 10, decoded op width; field use: [9] branch, [8] must_jump (JAL/JALR), [6:4] funct3, [3] jalr select
- FLUSH_DEPTH, 2, post-handshake flush cycles (0..15)

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_de  in  1  instruction in Execute is valid
- decoded_op_de  in  OPLEN  decoded op
- comp_out  in  1  comparator result, same cycle as decoded_op_de
- pc_de  in  XLEN  PC of instruction in Execute
- imm_de  in  XLEN  sign-extended immediate
- rs1data_de  in  XLEN  rs1 value (JALR base)
- redirect_valid  out  1  redirect request to Fetch
- redirect_pc  out  XLEN  target PC, stable while redirect_valid
- redirect_ready  in  1  Fetch accepts redirect
- flush_de  out  1  kill younger instructions in Decode/Execute
- stall_de  out  1  hold Decode; asserted whenever busy
- misalign_exc  out  1  one-cycle misaligned-target pulse (only with MISALIGN_EXC_EN)

## Operation
- take = valid_de & ~busy & (decoded_op_de[8] | (decoded_op_de[9] & comp_out)).
- Target: decoded_op_de[3]=1 → (rs1data_de + imm_de) & ~1; otherwise pc_de + imm_de. Mod 2^XLEN, wrap-around ignored.
- Not-taken branches and non-control ops: no outputs change, no state change.
- FSM states:
  - IDLE: on take, latch the target into redirect_pc and go to REQ.
  - REQ: redirect_valid=1, flush_de=1, stall_de=1.
    - On redirect_ready: FLUSH_DEPTH>0 → load cnt=FLUSH_DEPTH-1 and go to FLUSH; FLUSH_DEPTH=0 → IDLE.
  - FLUSH: flush_de=1, stall_de=1. cnt==0 → IDLE, else cnt-1.
- busy = (state != IDLE). While busy, valid_de is ignored. The instruction in Execute during REQ/FLUSH is wrong-path and is already killed by flush_de.
- redirect_pc holds its value after the handshake until the next take.
- Reset: state=IDLE, cnt=0, redirect_valid=0, redirect_pc=0, flush_de=0, stall_de=0, misalign_exc=0. Reset mid-REQ drops the request with no handshake.

## Timing
- Take sampled at edge T; redirect_valid/flush_de/stall_de high from after edge T (latency 1).
- A handshake occurs on an edge with redirect_valid & redirect_ready. redirect_ready high in the first REQ cycle gives a single-cycle REQ.
- Minimum busy cycles per redirect = 1 + FLUSH_DEPTH.
- A take is accepted in the first cycle after returning to IDLE. Back-to-back redirects are spaced by the busy time.
- redirect_ready while in IDLE/FLUSH is ignored.

## Configuration
- MISALIGN_EXC_EN defined: a computed target with target[1]=1 does not enter REQ. Instead misalign_exc pulses for 1 cycle (after edge T), flush_de pulses for 1 cycle with it, and state stays IDLE.
- Undefined: no alignment check; misalign_exc tied 0; every take enters REQ.

## Test plan
- BEQ taken: op[9]=1, funct3=000, comp_out=1, pc=0x100, imm=0x20 → next cycle redirect_valid=1, redirect_pc=0x120, flush_de=1; ready at cycle 3 → flush_de stays high 2 more cycles, then IDLE.
- BNE not-taken: op[9]=1, comp_out=0 → redirect_valid and flush_de stay 0 for all cycles.
- JALR: op[8]=1, op[3]=1, rs1=0x1003, imm=0x4 → redirect_pc=0x1006 (bit0 cleared); comp_out=0 is ignored.
- Back-pressure/busy: redirect_ready low for 5 cycles → redirect_pc stable and stall_de high. A second take arriving while busy is ignored and produces no new redirect_pc.
- Reset mid-REQ: assert rst_n=0 with redirect_valid=1 → all outputs 0 immediately (asynchronous); after release, IDLE.
- MISALIGN_EXC_EN: JAL with pc=0x200, imm=0x2 → misalign_exc=1 for one cycle, redirect_valid stays 0. Without the macro → redirect_pc=0x202.
